// File: rtl/psk_pkg.sv
// Shared definitions for the PSK link: FSM state encoding and default timing constants.
// The receiver imports the same package so both ends agree on symbol timing.
package psk_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPreamble = 2'd1,
    StData     = 2'd2
  } psk_state_e;

  localparam int unsigned DefCarrierHalf    = 5;
  localparam int unsigned DefCarriersPerSym = 2;
  localparam int unsigned DefPreambleSyms   = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psk_carrier_gen.sv
// Symbol timing for the PSK transmitter: sample counter within a symbol, square-wave
// carrier bit, and first/last-sample flags. All outputs describe the current sample.
module psk_carrier_gen
  import psk_pkg::*;
#(
  parameter int unsigned CARRIER_HALF     = DefCarrierHalf,
  parameter int unsigned CARRIERS_PER_SYM = DefCarriersPerSym
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic carrier_o,
  output logic sym_start_o,
  output logic sym_last_o
);

  localparam int unsigned SymLen  = 2 * CARRIER_HALF * CARRIERS_PER_SYM;
  localparam int unsigned SampleW = cnt_w(SymLen);
  localparam int unsigned HalfW   = cnt_w(CARRIER_HALF);

  localparam logic [SampleW-1:0] SampleLast = SampleW'(SymLen - 1);
  localparam logic [HalfW-1:0]   HalfLast   = HalfW'(CARRIER_HALF - 1);

  logic [SampleW-1:0] sample_d, sample_q;
  logic [HalfW-1:0]   half_d, half_q;
  logic               carrier_d, carrier_q;

  assign sym_start_o = (sample_q == '0);
  assign sym_last_o  = (sample_q == SampleLast);
  assign carrier_o   = carrier_q;

  // Advance one sample per enabled cycle; the symbol end re-aligns the carrier to 0.
  always_comb begin
    sample_d  = sample_q;
    half_d    = half_q;
    carrier_d = carrier_q;
    if (clr_i) begin
      sample_d  = '0;
      half_d    = '0;
      carrier_d = 1'b0;
    end else if (en_i) begin
      if (sym_last_o) begin
        sample_d  = '0;
        half_d    = '0;
        carrier_d = 1'b0;
      end else begin
        sample_d = sample_q + SampleW'(1);
        if (half_q == HalfLast) begin
          half_d    = '0;
          carrier_d = ~carrier_q;
        end else begin
          half_d = half_q + HalfW'(1);
        end
      end
    end
  end

  // Counter and carrier state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_q  <= '0;
      half_q    <= '0;
      carrier_q <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      half_q    <= half_d;
      carrier_q <= carrier_d;
    end
  end

endmodule

// File: rtl/psk_encoder_tx.sv
// Differential BPSK transmitter. Takes bytes over valid/ready, sends a preamble of
// phase flips, then data bits LSB first; a '1' inverts carrier phase at symbol start.
// Internal state describes the sample being computed; line outputs are registered one
// cycle later, so the first preamble sample appears after the edge following the transfer.
module psk_encoder_tx
  import psk_pkg::*;
#(
  parameter int unsigned CARRIER_HALF     = DefCarrierHalf,
  parameter int unsigned CARRIERS_PER_SYM = DefCarriersPerSym,
  parameter int unsigned PREAMBLE_SYMS    = DefPreambleSyms,
  parameter int unsigned DATA_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              psk_signal,
  output logic              tx_active,
  output logic              sym_strobe
);

  localparam int unsigned BitW = cnt_w(max_u(DATA_W, PREAMBLE_SYMS));

  localparam logic [BitW-1:0] PreLast  = BitW'(PREAMBLE_SYMS - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_W - 1);

  psk_state_e        state_d, state_q;
  logic [DATA_W-1:0] sr_d, sr_q;
  logic [BitW-1:0]   bit_d, bit_q;
  logic              phase_d, phase_q;
  logic              psk_d, psk_q;
  logic              active_d, active_q;
  logic              strobe_d, strobe_q;

  logic running;
  logic word_end;
  logic take;
  logic sym_bit;
  logic phase_cur;
  logic gen_clr;
  logic carrier;
  logic sym_start;
  logic sym_last;

  psk_carrier_gen #(
    .CARRIER_HALF    (CARRIER_HALF),
    .CARRIERS_PER_SYM(CARRIERS_PER_SYM)
  ) u_carrier_gen (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (running),
    .clr_i      (gen_clr),
    .carrier_o  (carrier),
    .sym_start_o(sym_start),
    .sym_last_o (sym_last)
  );

  assign running  = (state_q != StIdle);
  assign word_end = (state_q == StData) && sym_last && (bit_q == DataLast);
  // Gated by rst directly so no handshake is advertised while reset is held.
  assign tx_ready = !rst && ((state_q == StIdle) || word_end);
  assign take     = tx_valid && tx_ready;
  assign gen_clr  = running && (state_d == StIdle);

  assign sym_bit   = (state_q == StPreamble) ? 1'b1 : sr_q[0];
  assign phase_cur = (running && sym_start) ? (phase_q ^ sym_bit) : phase_q;

  assign psk_signal = psk_q;
  assign tx_active  = active_q;
  assign sym_strobe = strobe_q;

  // Next-state: frame sequencing, word latch/shift, symbol count and phase update.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bit_d    = bit_q;
    phase_d  = phase_cur;
    psk_d    = running && (carrier ^ phase_cur);
    active_d = running;
    strobe_d = running && sym_start;
    unique case (state_q)
      StIdle: begin
        phase_d = 1'b0;
        if (take) begin
          sr_d    = tx_data;
          bit_d   = '0;
          state_d = StPreamble;
        end
      end
      StPreamble: begin
        if (sym_last) begin
          if (bit_q == PreLast) begin
            bit_d   = '0;
            state_d = StData;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StData: begin
        if (sym_last) begin
          if (bit_q == DataLast) begin
            bit_d = '0;
            if (take) begin
              sr_d = tx_data;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
            sr_d  = sr_q >> 1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM, datapath and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      psk_q    <= 1'b0;
      active_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      psk_q    <= psk_d;
      active_q <= active_d;
      strobe_q <= strobe_d;
    end
  end

endmodule
